muldiv_controller: RTL and testbench

- Sequencer and iterative datapath for the RV32M multiply/divide instructions, sitting beside the main ALU in the EX stage.
- Holds the pipeline (stall) while a radix-2 shift-add multiply or restoring divide runs for DATA_W iterations.
- Presents a one-cycle done/Result pulse to the EX-stage result mux.
- Selected by the decoder when Funct7 = 0000001 on an R-type instruction; Funct3 chooses the operation.

---
 rtl/muldiv_controller.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_controller.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide over DATA_W cycles.
// Optional stall-cycle counter output StallCycles enabled by defining MULDIV_PERF_CNT_EN.
module muldiv_controller #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Result
`ifdef MULDIV_PERF_CNT_EN
  ,
  output logic [31:0]       StallCycles
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [2:0]         op;
  logic               neg_a;
  logic               neg_b;
  logic [DATA_W-1:0]  opnd;
  logic [DATA_W-1:0]  acc_hi;
  logic [DATA_W-1:0]  acc_lo;
  logic [CNT_W-1:0]   cnt;
  logic               done_q;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  // Operand decode at issue
  logic                     sgn_a_in;
  logic                     sgn_b_in;
  logic signed [DATA_W-1:0] src_a_s;
  logic signed [DATA_W-1:0] src_b_s;
  logic [DATA_W-1:0]        mag_a_in;
  logic [DATA_W-1:0]        mag_b_in;
  logic                     div_zero;
  logic                     div_ovf;
  logic [DATA_W-1:0]        fast_res;

  always_comb begin
    src_a_s  = SrcA;
    src_b_s  = SrcB;
    sgn_a_in = (src_a_s < 0) &&
               (Funct3 == F_MULH || Funct3 == F_MULHSU || Funct3 == F_DIV || Funct3 == F_REM);
    sgn_b_in = (src_b_s < 0) && (Funct3 == F_MULH || Funct3 == F_DIV || Funct3 == F_REM);
    mag_a_in = cond_neg(SrcA, sgn_a_in);
    mag_b_in = cond_neg(SrcB, sgn_b_in);
    div_zero = Funct3[2] && (SrcB == '0);
    div_ovf  = (Funct3 == F_DIV || Funct3 == F_REM) &&
               (SrcA == {1'b1, {(DATA_W-1){1'b0}}}) && (src_b_s == -1);
    if (div_zero) fast_res = Funct3[1] ? SrcA : '1;
    else          fast_res = Funct3[1] ? '0 : SrcA;
  end

  // One iteration: multiply adds/shifts right, divide shifts left/subtracts
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W-1:0]   div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   nxt_hi;
  logic [DATA_W-1:0]   nxt_lo;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   calc_res;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[DATA_W-1]};
    div_diff  = div_shift[DATA_W-1:0] - opnd;
    div_ge    = (div_shift >= {1'b0, opnd});
    if (op[2]) begin
      nxt_hi = div_ge ? div_diff : div_shift[DATA_W-1:0];
      nxt_lo = {acc_lo[DATA_W-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[DATA_W:1];
      nxt_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
    end
    prod = cond_neg2({nxt_hi, nxt_lo}, neg_a ^ neg_b);
    case (op)
      F_MUL:                     calc_res = prod[DATA_W-1:0];
      F_MULH, F_MULHSU, F_MULHU: calc_res = prod[2*DATA_W-1:DATA_W];
      F_DIV, F_DIVU:             calc_res = cond_neg(nxt_lo, neg_a ^ neg_b);
      default:                   calc_res = cond_neg(nxt_hi, neg_a);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !flush) begin
            op     <= Funct3;
            neg_a  <= sgn_a_in;
            neg_b  <= sgn_b_in;
            cnt    <= CNT_W'(DATA_W-1);
            acc_hi <= '0;
            opnd   <= Funct3[2] ? mag_b_in : mag_a_in;
            acc_lo <= Funct3[2] ? mag_a_in : mag_b_in;
            if (div_zero || div_ovf) begin
              state  <= DONE;
              Result <= fast_res;
              done_q <= 1'b1;
            end else begin
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
              state  <= DONE;
              Result <= calc_res;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush during DONE hides the pulse so the squashed result is never captured
  assign done  = done_q && !flush;
  assign busy  = (state != IDLE);
  assign stall = ((state == IDLE) && start && !flush) || (state == CALC);

`ifdef MULDIV_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      StallCycles <= '0;
    else if (stall) StallCycles <= StallCycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller: directed RV32M vectors, latency, flush and async reset.
module tb_muldiv_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
`ifdef MULDIV_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];

  muldiv_controller #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .Funct3 (funct3),
    .SrcA   (src_a),
    .SrcB   (src_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .Result (result)
`ifdef MULDIV_PERF_CNT_EN
    ,
    .StallCycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        check(n, result, e);
      end
    end
  end

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int exp_done, input int exp_stall);
    int stall_n;
    int done_at;
    stall_n = 0;
    done_at = -1;
    @(posedge clk); #1;
    funct3 = f; src_a = a; src_b = b; start = 1'b1;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (done && done_at < 0) done_at = c;
      @(posedge clk); #1;
      start = 1'b0;
      if (done_at >= 0) break;
    end
    check({nm, "_done_cycle"}, done_at, exp_done);
    check({nm, "_stall_cycles"}, stall_n, exp_stall);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int done_n;
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; src_a = '0; src_b = '0;
    #2 reset = 1'b1;
    @(negedge clk);
    check("reset_stall",  {31'd0, stall}, 32'd0);
    check("reset_busy",   {31'd0, busy},  32'd0);
    check("reset_done",   {31'd0, done},  32'd0);
    check("reset_result", result,         32'd0);
`ifdef MULDIV_PERF_CNT_EN
    check("reset_stallcycles", stall_cycles, 32'd0);
`endif
    @(posedge clk); #1 reset = 1'b0;

    run_op("mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 33);
    run_op("mulhu_m1_m1",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 33);
    run_op("mulh_m1_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 33);
    run_op("mulhsu_m1_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 33);

    run_op("divu_5_0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1);
    run_op("rem_5_0",      3'b110, 32'd5,        32'd0,        32'd5,        1, 1);
    run_op("div_min_m1",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
    run_op("rem_min_m1",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1);

    run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33);
    run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33);
    run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        32'd14,       33, 33);
    run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        32'd2,        33, 33);

    // Flush a DIV in c10; Result must keep the REMU value 2
    @(posedge clk); #1;
    funct3 = 3'b100; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_c11",   {31'd0, busy},  32'd0);
    check("flush_stall_c11",  {31'd0, stall}, 32'd0);
    check("flush_result_c11", result,         32'd2);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("flush_no_done", done_n, 32'd0);
    check("flush_result_hold", result, 32'd2);

    run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 33, 33);

    // Asynchronous reset mid-CALC, checked before the next clock edge
    @(posedge clk); #1;
    funct3 = 3'b000; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("calc_busy_before_reset", {31'd0, busy}, 32'd1);
    #3 reset = 1'b1;
    #1;
    check("async_reset_stall",  {31'd0, stall}, 32'd0);
    check("async_reset_busy",   {31'd0, busy},  32'd0);
    check("async_reset_done",   {31'd0, done},  32'd0);
    check("async_reset_result", result,         32'd0);
`ifdef MULDIV_PERF_CNT_EN
    check("async_reset_stallcycles", stall_cycles, 32'd0);
`endif
    @(posedge clk); #1 reset = 1'b0;

`ifdef MULDIV_PERF_CNT_EN
    run_op("perf_mul_a", 3'b000, 32'd2, 32'd3, 32'd6,  33, 33);
    run_op("perf_mul_b", 3'b000, 32'd4, 32'd5, 32'd20, 33, 33);
    check("stallcycles_two_muls", stall_cycles, 32'd66);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
